// File: rtl/paint_pkg.sv
// Shared types for the brush painting read-modify-write path: FSM states, RGB555 pixel and pack helpers.
package paint_pkg;

  localparam int PIXEL_W = 5;
  localparam logic [PIXEL_W-1:0] MAX_PIXEL_COLOR = 5'd31;
  localparam logic [3*PIXEL_W-1:0] WHITE_PIXEL = 15'h7FFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_BLEND   = 3'd3,
    ST_WR_REQ  = 3'd4
  } state_t;

  typedef struct packed {
    logic [PIXEL_W-1:0] r;
    logic [PIXEL_W-1:0] g;
    logic [PIXEL_W-1:0] b;
  } pixel_t;

  // Frame buffer words carry the colour in the low 15 bits; bit 15 is always written as zero.
  function automatic logic [15:0] pack_pixel(input pixel_t p);
    return {1'b0, p};
  endfunction

  function automatic pixel_t unpack_pixel(input logic [3*PIXEL_W-1:0] w);
    return pixel_t'(w);
  endfunction

endpackage

// File: rtl/paint_blend_ctrl_color_blend.sv
// color_blend: combinational multiplicative paint blend, out = stored * draw / 31 per channel.
module color_blend
  import paint_pkg::*;
(
  input  pixel_t stored,
  input  pixel_t draw,
  output pixel_t blended
);

  // A full-intensity stored channel passes the draw colour through unchanged.
  function automatic logic [PIXEL_W-1:0] mul_chan(input logic [PIXEL_W-1:0] s,
                                                  input logic [PIXEL_W-1:0] d);
    logic [2*PIXEL_W-1:0] prod;
    logic [2*PIXEL_W-1:0] quot;
    prod = {{PIXEL_W{1'b0}}, s} * {{PIXEL_W{1'b0}}, d};
    quot = prod / {{PIXEL_W{1'b0}}, MAX_PIXEL_COLOR};
    return quot[PIXEL_W-1:0];
  endfunction

  assign blended.r = mul_chan(stored.r, draw.r);
  assign blended.g = mul_chan(stored.g, draw.g);
  assign blended.b = mul_chan(stored.b, draw.b);

endmodule

// File: rtl/paint_blend_ctrl.sv
// paint_blend_ctrl: pixel read-modify-write sequencer towards the SDRAM controller with a 1-entry cache.
// Optional erase requests (direct white write) are compiled in with PAINT_ERASER_EN.
module paint_blend_ctrl
  import paint_pkg::*;
#(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [9:0]        i_req_x,
  input  logic [8:0]        i_req_y,
  input  logic [4:0]        i_req_R,
  input  logic [4:0]        i_req_G,
  input  logic [4:0]        i_req_B,
`ifdef PAINT_ERASER_EN
  input  logic              i_req_erase,
`endif
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic              o_sdram_read,
  output logic              o_sdram_write,
  output logic [15:0]       o_sdram_wdata,
  input  logic              i_sdram_waitrequest,
  input  logic [15:0]       i_sdram_rdata,
  input  logic              i_sdram_rdata_valid,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  state_t            state_r, next_state_s;
  logic [ADDR_W-1:0] addr_r, cache_addr_r, req_addr_s;
  pixel_t            draw_r, stored_r, cache_pix_r, blend_s;
  logic [15:0]       wdata_r;
  logic              cache_valid_r, done_r, err_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              accept_s, in_range_s, cache_hit_s, timeout_s, erase_s;
  logic              rdata_unused;

`ifdef PAINT_ERASER_EN
  assign erase_s = i_req_erase;
`else
  assign erase_s = 1'b0;
`endif

  assign rdata_unused = i_sdram_rdata[15];
  assign req_addr_s   = ADDR_W'(i_req_y) * ADDR_W'(H_RES) + ADDR_W'(i_req_x);
  assign in_range_s   = (32'(i_req_x) < H_RES) && (32'(i_req_y) < V_RES);
  assign cache_hit_s  = cache_valid_r && (cache_addr_r == req_addr_s);
  assign accept_s     = i_req_valid && o_req_ready;
  assign timeout_s    = (cnt_r == CNT_W'(RD_TIMEOUT - 1));

  color_blend u_blend (
    .stored (stored_r),
    .draw   (draw_r),
    .blended(blend_s)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && in_range_s) begin
          if (erase_s)          next_state_s = ST_WR_REQ;
          else if (cache_hit_s) next_state_s = ST_BLEND;
          else                  next_state_s = ST_RD_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RD_REQ:  next_state_s = i_sdram_waitrequest ? ST_RD_REQ : ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i_sdram_rdata_valid) next_state_s = ST_BLEND;
        else if (timeout_s)      next_state_s = ST_IDLE;
        else                     next_state_s = ST_RD_WAIT;
      end
      ST_BLEND:   next_state_s = ST_WR_REQ;
      ST_WR_REQ:  next_state_s = i_sdram_waitrequest ? ST_WR_REQ : ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so reset removes them in the same cycle.
  always_comb begin
    o_req_ready   = 1'b0;
    o_sdram_read  = 1'b0;
    o_sdram_write = 1'b0;
    case (state_r)
      ST_IDLE:   o_req_ready   = !i_rst;
      ST_RD_REQ: o_sdram_read  = 1'b1;
      ST_WR_REQ: o_sdram_write = 1'b1;
      default:   o_req_ready   = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_r        <= '0;
      draw_r        <= '0;
      stored_r      <= '0;
      wdata_r       <= 16'h0000;
      cache_valid_r <= 1'b0;
      cache_addr_r  <= '0;
      cache_pix_r   <= '0;
      cnt_r         <= '0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r <= req_addr_s;
            draw_r <= pixel_t'({i_req_R, i_req_G, i_req_B});
            if (!in_range_s)      done_r   <= 1'b1;
            else if (erase_s)     wdata_r  <= {1'b0, WHITE_PIXEL};
            else if (cache_hit_s) stored_r <= cache_pix_r;
          end
        end
        ST_RD_REQ: cnt_r <= '0;
        ST_RD_WAIT: begin
          if (i_sdram_rdata_valid) begin
            stored_r <= unpack_pixel(i_sdram_rdata[14:0]);
          end else if (timeout_s) begin
            err_r         <= 1'b1;
            cache_valid_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_BLEND: wdata_r <= pack_pixel(blend_s);
        ST_WR_REQ: begin
          if (!i_sdram_waitrequest) begin
            cache_valid_r <= 1'b1;
            cache_addr_r  <= addr_r;
            cache_pix_r   <= unpack_pixel(wdata_r[14:0]);
            done_r        <= 1'b1;
          end
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  assign o_sdram_addr  = addr_r;
  assign o_sdram_wdata = wdata_r;
  assign o_done        = done_r;
  assign o_err         = err_r;

endmodule

// File: tb/tb_paint_blend_ctrl.sv
// Self-checking bench for paint_blend_ctrl: behavioural SDRAM with wait states, write scoreboard, vector table.
// Erase-path checks are compiled in with PAINT_ERASER_EN.
`timescale 1ns/1ps
module tb_paint_blend_ctrl;

  localparam int ADDR_W = 23;
  localparam int L_RD   = 2;
  localparam int RD_TO  = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [9:0]        req_x = '0;
  logic [8:0]        req_y = '0;
  logic [4:0]        req_r = '0, req_g = '0, req_b = '0;
  logic              req_erase = 1'b0;
  logic [ADDR_W-1:0] sd_addr;
  logic              sd_read, sd_write;
  logic [15:0]       sd_wdata;
  logic              sd_waitreq = 1'b0;
  logic [15:0]       sd_rdata = 16'h0000;
  logic              sd_rvalid = 1'b0;
  logic              done, err;

  always #5 clk = ~clk;

  paint_blend_ctrl #(.H_RES(640), .V_RES(480), .ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y),
    .i_req_R(req_r), .i_req_G(req_g), .i_req_B(req_b),
`ifdef PAINT_ERASER_EN
    .i_req_erase(req_erase),
`endif
    .o_sdram_addr(sd_addr), .o_sdram_read(sd_read), .o_sdram_write(sd_write),
    .o_sdram_wdata(sd_wdata), .i_sdram_waitrequest(sd_waitreq),
    .i_sdram_rdata(sd_rdata), .i_sdram_rdata_valid(sd_rvalid),
    .o_done(done), .o_err(err)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic [15:0] wdata; } wr_exp_t;
  typedef struct { int x, y, r, g, b; logic [15:0] stored; int wrd, wwr; int addr; logic [15:0] wd; } vec_t;

  wr_exp_t           wr_q[$];
  logic [15:0]       mem [int];
  int                n_checks = 0, n_errors = 0;
  int                wait_rd = 0, wait_wr = 0, no_rdata = 0;
  int                reads = 0, writes = 0;
  logic [ADDR_W-1:0] exp_rd_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SDRAM model: wait states per strobe, read data returned L_RD cycles after the read is taken.
  int                hold = 0, pend = 0;
  logic [ADDR_W-1:0] rd_addr = '0, prev_addr = '0;
  logic              prev_held_rd = 1'b0, prev_held_wr = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold = 0; pend = 0; sd_waitreq = 1'b0; sd_rvalid = 1'b0;
      prev_held_rd = 1'b0; prev_held_wr = 1'b0;
    end else begin
      if (prev_held_rd) begin
        check("read_held", 32'(sd_read), 32'd1);
        check("read_addr_stable", 32'(sd_addr), 32'(prev_addr));
      end
      if (prev_held_wr) begin
        check("write_held", 32'(sd_write), 32'd1);
        check("write_addr_stable", 32'(sd_addr), 32'(prev_addr));
      end
      sd_rvalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          sd_rvalid = 1'b1;
          sd_rdata  = mem[int'(rd_addr)];
        end
      end
      if (sd_read || sd_write) begin
        check("strobe_exclusive", 32'(sd_read && sd_write), 32'd0);
        if (hold < (sd_read ? wait_rd : wait_wr)) begin
          sd_waitreq = 1'b1;
          hold++;
        end else begin
          sd_waitreq = 1'b0;
          hold = 0;
          if (sd_read) begin
            reads++;
            check("read_addr", 32'(sd_addr), 32'(exp_rd_addr));
            rd_addr = sd_addr;
            if (no_rdata == 0) pend = L_RD;
          end else begin
            writes++;
            if (wr_q.size() == 0) begin
              check("unexpected_write", 32'(sd_addr), 32'hFFFF_FFFF);
            end else begin
              wr_exp_t e;
              e = wr_q.pop_front();
              check("write_addr", 32'(sd_addr), 32'(e.addr));
              check("write_data", 32'(sd_wdata), 32'(e.wdata));
            end
            mem[int'(sd_addr)] = sd_wdata;
          end
        end
      end else begin
        sd_waitreq = 1'b0;
        hold = 0;
      end
      prev_held_rd = sd_read && sd_waitreq;
      prev_held_wr = sd_write && sd_waitreq;
      prev_addr    = sd_addr;
    end
  end

  // Issue one request at a negedge and wait (bounded) for o_done or o_err; lat counts cycles after accept.
  task automatic do_req(input int x, input int y, input int r, input int g, input int b, input bit erase,
                        input int addr, input bit exp_wr, input logic [15:0] exp_wd,
                        output int lat, output bit got_err);
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("ready_before_req", 32'(req_ready), 32'd1);
    exp_rd_addr = ADDR_W'(addr);
    if (exp_wr) wr_q.push_back('{ADDR_W'(addr), exp_wd});
    req_x = 10'(x); req_y = 9'(y); req_r = 5'(r); req_g = 5'(g); req_b = 5'(b);
    req_erase = erase;
    req_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      req_erase = 1'b0;
    end while (!done && !err && n < 400);
    if (!done && !err) check("req_retire_timeout", 32'(n), 32'd0);
    lat = n;
    got_err = err;
    @(negedge clk);
    check("retire_pulse_1cyc", 32'(done || err), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int lat, r0, w0, n;
    bit e;
    vecs[0] = '{3,   2,   10, 20, 31, 16'h7FFF, 0, 0, 1283,   16'h2A9F};
    vecs[1] = '{0,   0,   0,  0,  0,  16'h0000, 5, 5, 0,      16'h0000};
    vecs[2] = '{639, 479, 31, 31, 31, 16'h9234, 0, 0, 307199, 16'h1234};
    vecs[3] = '{100, 50,  16, 8,  1,  16'h4210, 2, 0, 32100,  16'h2080};
    vecs[4] = '{5,   1,   20, 25, 30, 16'h7C0F, 0, 3, 645,    16'h500E};

    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_read",   32'(sd_read),   32'd0);
    check("rst_write",  32'(sd_write),  32'd0);
    check("rst_addr",   32'(sd_addr),   32'd0);
    check("rst_wdata",  32'(sd_wdata),  32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_err",    32'(err),       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      wait_rd = vecs[i].wrd; wait_wr = vecs[i].wwr;
      mem[vecs[i].addr] = vecs[i].stored;
      r0 = reads; w0 = writes;
      do_req(vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g, vecs[i].b, 1'b0,
             vecs[i].addr, 1'b1, vecs[i].wd, lat, e);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(L_RD + 4 + vecs[i].wrd + vecs[i].wwr));
      check($sformatf("vec%0d_reads", i),  32'(reads - r0),  32'd1);
      check($sformatf("vec%0d_writes", i), 32'(writes - w0), 32'd1);
      check($sformatf("vec%0d_err", i),    32'(e),           32'd0);
    end
    wait_rd = 0; wait_wr = 0;

    // Same pixel again: served from the cache, blended with the previous result.
    r0 = reads; w0 = writes;
    do_req(5, 1, 31, 0, 16, 1'b0, 645, 1'b1, 16'h5007, lat, e);
    check("hit_latency", 32'(lat), 32'd3);
    check("hit_no_read", 32'(reads - r0), 32'd0);
    check("hit_writes",  32'(writes - w0), 32'd1);

    // Out-of-range requests retire without touching SDRAM.
    r0 = reads; w0 = writes;
    do_req(640, 0, 1, 2, 3, 1'b0, 640, 1'b0, 16'h0000, lat, e);
    check("oor_x_latency", 32'(lat), 32'd1);
    do_req(0, 480, 1, 2, 3, 1'b0, 307200, 1'b0, 16'h0000, lat, e);
    check("oor_y_latency", 32'(lat), 32'd1);
    check("oor_no_access", 32'((reads - r0) + (writes - w0)), 32'd0);
    check("oor_err", 32'(e), 32'd0);

    // Read data never returns: abort with o_err, no write, cache dropped.
    no_rdata = 1;
    mem[4487] = 16'h7FFF;
    r0 = reads; w0 = writes;
    do_req(7, 7, 9, 9, 9, 1'b0, 4487, 1'b0, 16'h0000, lat, e);
    check("to_err", 32'(e), 32'd1);
    check("to_latency", 32'(lat), 32'(RD_TO + 2));
    check("to_no_write", 32'(writes - w0), 32'd0);
    check("to_read", 32'(reads - r0), 32'd1);
    no_rdata = 0;
    r0 = reads;
    do_req(5, 1, 31, 31, 31, 1'b0, 645, 1'b1, 16'h5007, lat, e);
    check("after_to_reread", 32'(reads - r0), 32'd1);
    check("after_to_latency", 32'(lat), 32'(L_RD + 4));

    // Reset while the write strobe is held by waitrequest.
    wait_wr = 30;
    mem[64200] = 16'h7FFF;
    w0 = writes;
    exp_rd_addr = ADDR_W'(64200);
    wr_q.push_back('{ADDR_W'(64200), 16'h0443});
    req_x = 10'd200; req_y = 9'd100; req_r = 5'd1; req_g = 5'd2; req_b = 5'd3; req_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); req_valid = 1'b0; n++; end while (!sd_write && n < 50);
    check("wr_reached", 32'(sd_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_write", 32'(sd_write), 32'd0);
    check("rstwr_read",  32'(sd_read),  32'd0);
    check("rstwr_addr",  32'(sd_addr),  32'd0);
    check("rstwr_wdata", 32'(sd_wdata), 32'd0);
    check("rstwr_done",  32'(done),     32'd0);
    wr_q.delete();
    wait_wr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstwr_no_write", 32'(writes - w0), 32'd0);
    r0 = reads;
    do_req(200, 100, 1, 2, 3, 1'b0, 64200, 1'b1, 16'h0443, lat, e);
    check("post_rst_reread", 32'(reads - r0), 32'd1);
    check("post_rst_latency", 32'(lat), 32'(L_RD + 4));

`ifdef PAINT_ERASER_EN
    mem[128300] = 16'h1111;
    r0 = reads;
    do_req(300, 200, 4, 4, 4, 1'b1, 128300, 1'b1, 16'h7FFF, lat, e);
    check("erase_latency", 32'(lat), 32'd2);
    check("erase_no_read", 32'(reads - r0), 32'd0);
    do_req(300, 200, 10, 20, 31, 1'b0, 128300, 1'b1, 16'h2A9F, lat, e);
    check("erase_cached", 32'(lat), 32'd3);
    check("erase_cached_no_read", 32'(reads - r0), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
